// File: rtl/divr4_iter_core.sv
// Radix-4 iterative integer divider: two quotient bits per cycle, signed/unsigned,
// zero-divisor and MIN/-1 handling. Optional macro DIVR4_EARLY_TERM_EN skips leading zero digit pairs.
module divr4_iter_core #(
   parameter int WIDTH    = 32,
   parameter int EXPWIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic             sign,
   input  logic [WIDTH-1:0] zdividend,
   input  logic [WIDTH-1:0] zdivisor,
   input  logic             out_ready,
   output logic             free,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             sign_o,
   output logic             div0
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_ITER = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam int                  PW     = WIDTH + 2;
   localparam logic [EXPWIDTH-1:0] HALF_W = EXPWIDTH'(WIDTH / 2);
   localparam logic [EXPWIDTH-1:0] ONE_C  = EXPWIDTH'(1);
   localparam logic [WIDTH-1:0]    MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]    ONES_V = {WIDTH{1'b1}};

`ifdef DIVR4_EARLY_TERM_EN
   function automatic logic [EXPWIDTH:0] clz(input logic [WIDTH-1:0] v);
      logic [EXPWIDTH:0] n;
      logic              hit;
      n   = '0;
      hit = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!hit && !v[i]) begin
            n = n + (EXPWIDTH+1)'(1);
         end else begin
            hit = 1'b1;
         end
      end
      return n;
   endfunction
`endif

   state_t               state_q, state_d;
   logic                 free_q, free_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [WIDTH-1:0]     r_q, r_d;
   logic                 sign_o_q, sign_o_d;
   logic                 div0_q, div0_d;
   logic [WIDTH-1:0]     opa_q, opa_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic                 sgn_q, sgn_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     dvd_q, dvd_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [EXPWIDTH-1:0]  cnt_q, cnt_d;
   logic                 negq_q, negq_d;
   logic                 negr_q, negr_d;
   logic                 byp0_q, byp0_d;
   logic                 bypov_q, bypov_d;

   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [PW-1:0]        p_shift, b1, b2, b3;
   logic [WIDTH-1:0]     sub_v;
   logic [1:0]           dig;
`ifdef DIVR4_EARLY_TERM_EN
   logic [EXPWIDTH:0]    lz;
   logic [EXPWIDTH-1:0]  half;
`endif

   // Magnitudes and radix-4 digit selection; P' is WIDTH+2 bits, only the low WIDTH bits survive subtraction.
   always_comb begin
      abs_a   = (sgn_q && opa_q[WIDTH-1]) ? -opa_q : opa_q;
      abs_b   = (sgn_q && opb_q[WIDTH-1]) ? -opb_q : opb_q;
      p_shift = {rem_q, dvd_q[WIDTH-1:WIDTH-2]};
      b1      = {2'b00, dvs_q};
      b2      = {1'b0, dvs_q, 1'b0};
      b3      = b1 + b2;
      if (p_shift >= b3) begin
         dig   = 2'd3;
         sub_v = b3[WIDTH-1:0];
      end else if (p_shift >= b2) begin
         dig   = 2'd2;
         sub_v = b2[WIDTH-1:0];
      end else if (p_shift >= b1) begin
         dig   = 2'd1;
         sub_v = b1[WIDTH-1:0];
      end else begin
         dig   = 2'd0;
         sub_v = '0;
      end
`ifdef DIVR4_EARLY_TERM_EN
      lz   = clz(abs_a);
      half = lz[EXPWIDTH:1];
`endif
   end

   // Next-state and datapath updates for the divider FSM.
   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      r_d      = r_q;
      sign_o_d = sign_o_q;
      div0_d   = div0_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      sgn_d    = sgn_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      byp0_d   = byp0_q;
      bypov_d  = bypov_q;

      case (state_q)
         S_IDLE: begin
            if (valid_in && free_q) begin
               opa_d   = zdividend;
               opb_d   = zdivisor;
               sgn_d   = sign;
               state_d = S_PRE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PRE: begin
            negq_d = sgn_q & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
            negr_d = sgn_q & opa_q[WIDTH-1];
            dvs_d  = abs_b;
            rem_d  = '0;
            quo_d  = '0;
            if (opb_q == '0) begin
               byp0_d  = 1'b1;
               bypov_d = 1'b0;
               state_d = S_POST;
            end else if (sgn_q && (opa_q == MIN_V) && (opb_q == ONES_V)) begin
               byp0_d  = 1'b0;
               bypov_d = 1'b1;
               state_d = S_POST;
            end else begin
               byp0_d  = 1'b0;
               bypov_d = 1'b0;
`ifdef DIVR4_EARLY_TERM_EN
               dvd_d   = abs_a << {half, 1'b0};
               cnt_d   = HALF_W - half;
               state_d = (half == HALF_W) ? S_POST : S_ITER;
`else
               dvd_d   = abs_a;
               cnt_d   = HALF_W;
               state_d = S_ITER;
`endif
            end
         end
         S_ITER: begin
            rem_d = p_shift[WIDTH-1:0] - sub_v;
            dvd_d = {dvd_q[WIDTH-3:0], 2'b00};
            quo_d = {quo_q[WIDTH-3:0], dig};
            cnt_d = cnt_q - ONE_C;
            if (cnt_q == ONE_C) begin
               state_d = S_POST;
            end else begin
               state_d = S_ITER;
            end
         end
         S_POST: begin
            sign_o_d = sgn_q;
            div0_d   = byp0_q;
            if (byp0_q) begin
               q_d = ONES_V;
               r_d = opa_q;
            end else if (bypov_q) begin
               q_d = MIN_V;
               r_d = '0;
            end else begin
               q_d = negq_q ? -quo_q : quo_q;
               r_d = negr_q ? -rem_q : rem_q;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      free_d = (state_d == S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         free_q   <= 1'b1;
         done_q   <= 1'b0;
         q_q      <= '0;
         r_q      <= '0;
         sign_o_q <= 1'b0;
         div0_q   <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         sgn_q    <= 1'b0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         byp0_q   <= 1'b0;
         bypov_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         free_q   <= free_d;
         done_q   <= done_d;
         q_q      <= q_d;
         r_q      <= r_d;
         sign_o_q <= sign_o_d;
         div0_q   <= div0_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         sgn_q    <= sgn_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         byp0_q   <= byp0_d;
         bypov_q  <= bypov_d;
      end
   end

   assign free   = free_q;
   assign done   = done_q;
   assign q      = q_q;
   assign r      = r_q;
   assign sign_o = sign_o_q;
   assign div0   = div0_q;

endmodule

// File: tb/tb_divr4_iter_core.sv
// Directed self-checking bench for divr4_iter_core (WIDTH=32), both early-termination builds.
module tb_divr4_iter_core;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic          sign;
   logic [W-1:0]  zdividend;
   logic [W-1:0]  zdivisor;
   logic          out_ready;
   logic          free;
   logic          done;
   logic [W-1:0]  q;
   logic [W-1:0]  r;
   logic          sign_o;
   logic          div0;

   int n_tests = 0;
   int n_fail  = 0;

   divr4_iter_core #(.WIDTH(W), .EXPWIDTH(5)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .sign(sign),
      .zdividend(zdividend), .zdivisor(zdivisor), .out_ready(out_ready),
      .free(free), .done(done), .q(q), .r(r), .sign_o(sign_o), .div0(div0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_free"}, free, 1);
      chk({tag, "_done_lo"}, done, 0);
   endtask

   task automatic do_op(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ed, input int lat_off, input int lat_on);
      int lat;
      int elat;
`ifdef DIVR4_EARLY_TERM_EN
      elat = lat_on;
`else
      elat = lat_off;
`endif
      @(negedge clk);
      sign      = s;
      zdividend = a;
      zdivisor  = b;
      valid_in  = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      chk({tag, "_busy"}, free, 0);
      wait_done(lat);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_q"}, q, eq);
      chk({tag, "_r"}, r, er);
      chk({tag, "_div0"}, div0, ed);
      chk({tag, "_sign_o"}, sign_o, s);
      release_result(tag);
   endtask

   initial begin
      int lat;
      rst       = 1'b1;
      valid_in  = 1'b0;
      sign      = 1'b0;
      zdividend = '0;
      zdivisor  = '0;
      out_ready = 1'b0;
      #12;
      chk("rst_free", free, 1);
      chk("rst_done", done, 0);
      chk("rst_q", q, 0);
      chk("rst_r", r, 0);
      chk("rst_sign_o", sign_o, 0);
      chk("rst_div0", div0, 0);
      @(negedge clk);
      rst = 1'b0;

      do_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 18, 6);
      do_op("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 18, 4);
      do_op("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 18, 4);
      do_op("s-7_-2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 18, 4);
      do_op("u_div0",   1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 2, 2);
      do_op("s_div0",   1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 2, 2);
      do_op("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 2, 2);
      do_op("u_min",    1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 18, 18);
      do_op("u_big",    1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 18, 18);
      do_op("u0_5",     1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 18, 2);
      do_op("u5_9",     1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 18, 4);

      // Backpressure: result held with valid_in asserted throughout
      @(negedge clk);
      sign      = 1'b0;
      zdividend = 32'd100;
      zdivisor  = 32'd7;
      valid_in  = 1'b1;
      @(posedge clk);
      #1;
      zdividend = 32'hFFFFFFFF;
      zdivisor  = 32'd3;
      wait_done(lat);
      chk("bp_first_done", done, 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_done", done, 1);
         chk("bp_hold_q", q, 32'd14);
         chk("bp_hold_r", r, 32'd2);
         chk("bp_hold_free", free, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_rel_free", free, 1);
      chk("bp_rel_done", done, 0);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      chk("bp_acc_busy", free, 0);
      wait_done(lat);
      chk("bp_next_lat", lat, 18);
      chk("bp_next_q", q, 32'h55555555);
      chk("bp_next_r", r, 32'd0);
      release_result("bp_next");

      // Reset pulse in the middle of iteration
      @(negedge clk);
      sign      = 1'b0;
      zdividend = 32'hFFFFFFFF;
      zdivisor  = 32'd7;
      valid_in  = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_done", done, 0);
      chk("midrst_q", q, 0);
      chk("midrst_free", free, 1);
      @(negedge clk);
      rst = 1'b0;
      do_op("post_rst", 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, 1'b0, 18, 18);
      do_op("u3_1",     1'b0, 32'd3,        32'd1, 32'd3,        32'd0, 1'b0, 18, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
